// File: rtl/tick_delay_pkg.sv
// ============================================================================
// Module      : tick_delay_pkg
// Description : Shared types, default sizing and the delay clamp helper for
//               the tick-delay timer.
//               Contents: delay_t (delay field type), DEFAULT_MAX_DELAY,
//               DEFAULT_RESET_DELAY, DELAY_W, clamp_delay().
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_delay_pkg;

  localparam int unsigned DEFAULT_MAX_DELAY   = 64;
  localparam int unsigned DEFAULT_RESET_DELAY = 4;
  localparam int unsigned DELAY_W             = $clog2(DEFAULT_MAX_DELAY + 1);

  typedef logic [DELAY_W-1:0] delay_t;

  // Forces a requested delay into the legal range 1..max_d.
  function automatic delay_t clamp_delay(input delay_t d, input delay_t max_d);
    if (d == '0) begin
      return delay_t'(1);
    end
    if (d > max_d) begin
      return max_d;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_delay_if.sv
// ============================================================================
// Module      : tick_delay_if
// Description : Signal bundle between the pulse source (master) and the
//               tick-delay timer (slave).
//               master drives : timer_input, delay, delay_load
//               slave drives  : timer_output, busy, delay_active
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_delay_if;
  import tick_delay_pkg::*;

  logic   timer_input;
  delay_t delay;
  logic   delay_load;
  logic   timer_output;
  logic   busy;
  delay_t delay_active;

  modport master (
    output timer_input,
    output delay,
    output delay_load,
    input  timer_output,
    input  busy,
    input  delay_active
  );

  modport slave (
    input  timer_input,
    input  delay,
    input  delay_load,
    output timer_output,
    output busy,
    output delay_active
  );

endinterface

`default_nettype wire

// File: rtl/bit_ring_buffer.sv
// ============================================================================
// Module      : bit_ring_buffer
// Description : Circular buffer of DEPTH single-bit samples. One bit is
//               written per clock; rd_bit presents the sample taken
//               (offset-1) clocks before the one being written now.
//               Ports: clk, rst_n (async, active low), wr_bit (sample in),
//               offset (delay in ticks, 1..DEPTH), rd_bit (delayed sample,
//               combinational, registered by the parent).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_ring_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned OFF_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_bit,
  input  logic [OFF_W-1:0] offset,
  output logic             rd_bit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  // One extra bit so wp + DEPTH + 1 - offset never underflows.
  localparam int unsigned IDX_W = OFF_W + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wp;
  logic [IDX_W-1:0] w_sum;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_direct;

  // offset 1 means the sample being written is the one to present, so it
  // bypasses storage entirely.
  assign w_direct = (offset <= OFF_W'(1));

  always_comb begin
    w_sum    = IDX_W'(r_wp) + IDX_W'(DEPTH + 1) - IDX_W'(offset);
    w_rd_ptr = PTR_W'((w_sum >= IDX_W'(DEPTH)) ? (w_sum - IDX_W'(DEPTH)) : w_sum);
  end

  assign rd_bit = w_direct ? wr_bit : r_mem[w_rd_ptr];

  // A slot is zeroed once its sample has been handed out, so every slot
  // outside the live window holds 0. That keeps a later increase of the
  // delay from resurrecting pulses that were already delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wp  <= '0;
    end else begin
      if (!w_direct) begin
        r_mem[w_rd_ptr] <= 1'b0;
      end
      r_mem[r_wp] <= w_direct ? 1'b0 : wr_bit;
      r_wp        <= (r_wp == PTR_W'(DEPTH - 1)) ? '0 : (r_wp + PTR_W'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_delay_timer.sv
// ============================================================================
// Module      : tick_delay_timer
// Description : Programmable tick-delay timer. timer_output reproduces
//               timer_input delayed by delay_active clock ticks. New delays
//               are applied only while no 1 is in flight, so pulses are
//               never lost or duplicated.
//               Ports: clk, rst_n (async assert, active low),
//               bus (slave): timer_input, delay, delay_load in;
//                            timer_output, busy, delay_active out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_delay_timer
  import tick_delay_pkg::*;
#(
  parameter int unsigned MAX_DELAY   = DEFAULT_MAX_DELAY,
  parameter int unsigned RESET_DELAY = DEFAULT_RESET_DELAY
) (
  input  logic         clk,
  input  logic         rst_n,
  tick_delay_if.slave  bus
);

  delay_t r_delay_active;
  delay_t r_pending_val;
  delay_t r_ones;
  logic   r_pending;
  logic   r_out;
  logic   r_busy;

  delay_t w_req;
  delay_t w_ones_next;
  delay_t w_active_next;
  delay_t w_pending_val_next;
  logic   w_pending_next;
  logic   w_busy_next;
  logic   w_quiet;
  logic   w_ring_bit;

  bit_ring_buffer #(
    .DEPTH (MAX_DELAY),
    .OFF_W (DELAY_W)
  ) u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_bit (bus.timer_input),
    .offset (r_delay_active),
    .rd_bit (w_ring_bit)
  );

  assign w_req = clamp_delay(bus.delay, delay_t'(MAX_DELAY));

  always_comb begin
    // The sample leaving the window on this edge is exactly the one that
    // is on the output right now.
    w_ones_next = r_ones;
    if (bus.timer_input && !r_out && (r_ones != r_delay_active)) begin
      w_ones_next = r_ones + delay_t'(1);
    end else if (!bus.timer_input && r_out && (r_ones != '0)) begin
      w_ones_next = r_ones - delay_t'(1);
    end

    // Window empty and nothing entering: safe point to switch delay.
    w_quiet = (r_ones == '0) && !bus.timer_input;

    w_active_next      = r_delay_active;
    w_pending_next     = r_pending;
    w_pending_val_next = r_pending_val;

    if (bus.delay_load) begin
      if (w_req == r_delay_active) begin
        w_pending_next = 1'b0;
      end else if (!r_busy && !bus.timer_input) begin
        w_active_next  = w_req;
        w_pending_next = 1'b0;
      end else begin
        w_pending_next     = 1'b1;
        w_pending_val_next = w_req;
      end
    end else if (r_pending && w_quiet) begin
      w_active_next  = r_pending_val;
      w_pending_next = 1'b0;
    end

    w_busy_next = (w_ones_next != '0) || w_pending_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_active <= delay_t'(RESET_DELAY);
      r_pending_val  <= delay_t'(RESET_DELAY);
      r_pending      <= 1'b0;
      r_ones         <= '0;
      r_out          <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_delay_active <= w_active_next;
      r_pending_val  <= w_pending_val_next;
      r_pending      <= w_pending_next;
      r_ones         <= w_ones_next;
      r_out          <= w_ring_bit;
      r_busy         <= w_busy_next;
    end
  end

  assign bus.timer_output = r_out;
  assign bus.busy         = r_busy;
  assign bus.delay_active = r_delay_active;

endmodule

`default_nettype wire

// File: tb/tb_tick_delay_timer.sv
// ============================================================================
// Module      : tb_tick_delay_timer
// Description : Directed self-checking bench for tick_delay_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_delay_timer;
  import tick_delay_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  tick_delay_if bus ();

  tick_delay_timer #(
    .MAX_DELAY   (64),
    .RESET_DELAY (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one input sample, let one posedge take it, land 1 time unit after.
  task automatic step(input logic ti);
    bus.timer_input = ti;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned v);
    bus.delay      = delay_t'(v);
    bus.delay_load = 1'b1;
    step(1'b0);
    bus.delay_load = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.timer_input = 1'b0;
    bus.delay      = '0;
    bus.delay_load = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_delay_active", 32'(bus.delay_active), 4);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_out", 32'(bus.timer_output), 0);

    // D=4 single pulse: out high only 3 edges later, busy through that edge
    step(1'b1);
    check("d4_e0_out", 32'(bus.timer_output), 0);
    check("d4_e0_busy", 32'(bus.busy), 1);
    for (int j = 1; j <= 5; j++) begin
      step(1'b0);
      check($sformatf("d4_e%0d_out", j), 32'(bus.timer_output), (j == 3) ? 1 : 0);
      check($sformatf("d4_e%0d_busy", j), 32'(bus.busy), (j <= 3) ? 1 : 0);
    end

    // D=1 while idle: immediate, then a plain register
    load(1);
    check("d1_active", 32'(bus.delay_active), 1);
    for (int j = 0; j < 8; j++) begin
      step(j[0]);
      check($sformatf("d1_toggle%0d", j), 32'(bus.timer_output), 32'(j[0]));
    end
    step(1'b0);
    check("d1_drain_busy", 32'(bus.busy), 0);

    // D=64: pulses at edges 0 and 63, outputs at 63 and 126 (wrap-around)
    load(64);
    check("d64_active", 32'(bus.delay_active), 64);
    step(1'b1);
    check("d64_e0_busy", 32'(bus.busy), 1);
    for (int e = 1; e <= 130; e++) begin
      step(e == 63);
      check($sformatf("d64_e%0d_out", e), 32'(bus.timer_output),
            (e == 63 || e == 126) ? 1 : 0);
      check($sformatf("d64_e%0d_busy", e), 32'(bus.busy), (e <= 126) ? 1 : 0);
    end

    // Clamping
    load(0);
    check("clamp_lo", 32'(bus.delay_active), 1);
    load(100);
    check("clamp_hi", 32'(bus.delay_active), 64);

    // Deferred load: D=8 pulse in flight, load 3 then 5, last wins after drain
    load(8);
    check("d8_active", 32'(bus.delay_active), 8);
    step(1'b1);                       // edge p
    bus.delay = delay_t'(3);
    bus.delay_load = 1'b1;
    step(1'b0);                       // p+1
    bus.delay = delay_t'(5);
    step(1'b0);                       // p+2
    bus.delay_load = 1'b0;
    check("defer_hold_p2", 32'(bus.delay_active), 8);
    check("defer_busy_p2", 32'(bus.busy), 1);
    for (int j = 3; j <= 7; j++) begin
      step(1'b0);
      check($sformatf("defer_hold_p%0d", j), 32'(bus.delay_active), 8);
      check($sformatf("defer_out_p%0d", j), 32'(bus.timer_output), (j == 7) ? 1 : 0);
    end
    step(1'b0);                       // p+8: window drains
    step(1'b0);                       // p+9: pending applied
    check("defer_applied", 32'(bus.delay_active), 5);
    check("defer_idle", 32'(bus.busy), 0);
    step(1'b1);                       // edge q
    for (int j = 1; j <= 6; j++) begin
      step(1'b0);
      check($sformatf("d5_q%0d_out", j), 32'(bus.timer_output), (j == 4) ? 1 : 0);
    end

    // Closed loop with an inverting clock generator, D=3 -> period 6
    load(3);
    check("loop_active", 32'(bus.delay_active), 3);
    for (int k = 0; k <= 20; k++) begin
      step(~bus.timer_output);
      check($sformatf("loop_k%0d", k), 32'(bus.timer_output), ((k + 1) / 3) % 2);
    end

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(bus.timer_output), 0);
    check("midrst_active", 32'(bus.delay_active), 4);
    check("midrst_busy", 32'(bus.busy), 0);
    bus.timer_input = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b0);
    check("postrst_out", 32'(bus.timer_output), 0);
    check("postrst_active", 32'(bus.delay_active), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
